// File: rtl/panel_cmd_sequencer_if.sv
// rtl/panel_cmd_sequencer_if.sv - momentary command valid/ready handshake to the panel controller
interface panel_cmd_sequencer_if;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/panel_cmd_sequencer.sv
// rtl/panel_cmd_sequencer.sv - cursor actions to latched switches and held momentary command pulses
module panel_cmd_sequencer #(
  parameter int                           SWITCHES_ST_COUNT  = 18,
  parameter int                           SWITCHES_MAX_INDEX = 24,
  parameter int                           MIN_HOLD           = 16,
  parameter logic [SWITCHES_ST_COUNT-1:0] SW_RESET           = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [4:0]                    cursor_index,
  input  logic [1:0]                    cursor_action,
  output logic [SWITCHES_ST_COUNT-1:0]  switches,
  panel_cmd_sequencer_if.master         cmd,
  output logic [SWITCHES_MAX_INDEX-SWITCHES_ST_COUNT:0] mom_up,
  output logic [SWITCHES_MAX_INDEX-SWITCHES_ST_COUNT:0] mom_dn,
  output logic                          busy,
  output logic                          cmd_dropped
);
  localparam int         MOM_N = SWITCHES_MAX_INDEX - SWITCHES_ST_COUNT + 1;
  localparam int         CW    = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [4:0] ST5   = 5'(SWITCHES_ST_COUNT);
  localparam logic [4:0] MAX5  = 5'(SWITCHES_MAX_INDEX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t                          r_state;
  logic [1:0]                      r_prev_action;
  logic [SWITCHES_ST_COUNT-1:0]    r_sw;
  logic                            r_cmd_valid;
  logic [3:0]                      r_cmd_code;
  logic                            r_pend_vld;
  logic [3:0]                      r_pend_code;
  logic [CW-1:0]                   r_cnt;
  logic [MOM_N-1:0]                r_mom_up;
  logic [MOM_N-1:0]                r_mom_dn;
  logic                            r_dropped;

  logic                            w_event;
  logic                            w_is_tog;
  logic                            w_new_cmd;
  logic [3:0]                      w_new_code;
  logic                            w_hold_exit;
  logic [MOM_N-1:0]                w_mom_sel;

  // 11 is a cursor move; only a change into a real action counts as an event
  assign w_event     = (cursor_action != r_prev_action) && (cursor_action != 2'b11);
  assign w_is_tog    = w_event && (cursor_index < ST5);
  assign w_new_cmd   = w_event && (cursor_index >= ST5) && (cursor_index <= MAX5)
                       && (cursor_action != 2'b00);
  assign w_new_code  = {3'(cursor_index - ST5), cursor_action == 2'b10};
  assign w_hold_exit = (r_state == S_HOLD) && (r_cnt == '0);
  assign w_mom_sel   = MOM_N'(1) << r_cmd_code[3:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_action <= 2'b11;
      r_sw          <= SW_RESET;
    end else begin
      r_prev_action <= cursor_action;
      if (w_is_tog) begin
        if (cursor_action == 2'b01)
          r_sw[cursor_index] <= 1'b1;
        else if (cursor_action == 2'b00)
          r_sw[cursor_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= '0;
      r_cnt       <= '0;
      r_mom_up    <= '0;
      r_mom_dn    <= '0;
      r_dropped   <= 1'b0;
    end else begin
      if (w_new_cmd && (r_state != S_IDLE)) begin
        if (!r_pend_vld) begin
          r_pend_vld  <= 1'b1;
          r_pend_code <= w_new_code;
        end else if (!w_hold_exit) begin
          r_dropped <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (r_pend_vld) begin
            r_cmd_code  <= r_pend_code;
            r_cmd_valid <= 1'b1;
            r_state     <= S_REQ;
            r_pend_vld  <= w_new_cmd;
            r_pend_code <= w_new_code;
          end else if (w_new_cmd) begin
            r_cmd_code  <= w_new_code;
            r_cmd_valid <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (cmd.cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_mom_up    <= r_cmd_code[0] ? '0 : w_mom_sel;
            r_mom_dn    <= r_cmd_code[0] ? w_mom_sel : '0;
            r_cnt       <= CW'(MIN_HOLD - 1);
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_mom_up <= '0;
            r_mom_dn <= '0;
            // full slot plus a new command: issue the queued one now so the new one has a home
            if (r_pend_vld && w_new_cmd) begin
              r_cmd_code  <= r_pend_code;
              r_cmd_valid <= 1'b1;
              r_pend_code <= w_new_code;
              r_state     <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign switches      = r_sw;
  assign cmd.cmd_valid = r_cmd_valid;
  assign cmd.cmd_code  = r_cmd_code;
  assign mom_up        = r_mom_up;
  assign mom_dn        = r_mom_dn;
  assign busy          = (r_state != S_IDLE) || r_pend_vld;
  assign cmd_dropped   = r_dropped;
endmodule
